// File: rtl/serial_compare_ctrl_pkg.sv
// Shared definitions for the serial magnitude-compare sequencer.
// State encodings are fixed so external checkers can decode the debug state.
package serial_compare_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Packed view of a finished comparison, handy for checkers and scoreboards.
  typedef struct packed {
    logic equal;
    logic lesser;
    logic greater;
  } cmp_flags_t;

endpackage

// File: rtl/serial_compare_ctrl_comparator_bit.sv
// Combinational 1-bit magnitude comparator cell; exactly one output is high.
module comparator_bit (
  input  logic a_i,
  input  logic b_i,
  output logic equal_o,
  output logic lesser_o,
  output logic greater_o
);

  assign equal_o   = a_i ~^ b_i;
  assign lesser_o  = ~a_i & b_i;
  assign greater_o = a_i & ~b_i;

endmodule

// File: rtl/serial_compare_ctrl.sv
// MSB-first serial magnitude comparator sequencer driving one shared 1-bit cell.
// Handshake: start is sampled only in IDLE; done pulses one cycle and results hold until the next accept.
module serial_compare_ctrl
  import serial_compare_ctrl_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int IDX_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             equal,
  output logic             lesser,
  output logic             greater,
  output logic [IDX_W-1:0] bits_used,
  output logic [1:0]       dbg_state
);

  state_e             state_q;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [IDX_W-1:0]   idx_q;
  logic               busy_q, done_q;
  cmp_flags_t         flags_q;
  logic [IDX_W-1:0]   bits_used_q;

  logic               a_bit, b_bit;
  logic               cell_eq, cell_lt, cell_gt;
  logic               scan_end;
  logic [IDX_W-1:0]   bits_used_d;

  // Mux the current bit by comparing against each position, keeping the index width free.
  always_comb begin
    a_bit = 1'b0;
    b_bit = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (idx_q == IDX_W'(i)) begin
        a_bit = a_q[i];
        b_bit = b_q[i];
      end
    end
  end

  comparator_bit u_cell (
    .a_i       (a_bit),
    .b_i       (b_bit),
    .equal_o   (cell_eq),
    .lesser_o  (cell_lt),
    .greater_o (cell_gt)
  );

  // Bit 0 always ends the scan, so idx never wraps.
  assign scan_end    = cell_gt | cell_lt | (cell_eq & (idx_q == '0));
  assign bits_used_d = IDX_W'(WIDTH) - idx_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      idx_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      flags_q     <= '0;
      bits_used_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            a_q         <= a;
            b_q         <= b;
            idx_q       <= IDX_W'(WIDTH - 1);
            flags_q     <= '0;
            bits_used_q <= '0;
            busy_q      <= 1'b1;
            state_q     <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (scan_end) begin
            flags_q.greater <= cell_gt;
            flags_q.lesser  <= cell_lt;
            flags_q.equal   <= cell_eq;
            bits_used_q     <= bits_used_d;
            done_q          <= 1'b1;
            state_q         <= S_DONE;
          end else begin
            idx_q <= idx_q - 1'b1;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign equal     = flags_q.equal;
  assign lesser    = flags_q.lesser;
  assign greater   = flags_q.greater;
  assign bits_used = bits_used_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_serial_compare_ctrl.sv
// Directed bench for serial_compare_ctrl: WIDTH=8 and WIDTH=1 instances with a result scoreboard.
module tb_serial_compare_ctrl;
  import serial_compare_ctrl_pkg::*;

  int checks = 0;
  int errors = 0;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT WIDTH=8 ----------------
  logic       start8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       busy8, done8, eq8, lt8, gt8;
  logic [3:0] bu8;
  logic [1:0] st8;

  serial_compare_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .equal(eq8), .lesser(lt8), .greater(gt8),
    .bits_used(bu8), .dbg_state(st8)
  );

  // ---------------- DUT WIDTH=1 ----------------
  logic       start1 = 1'b0;
  logic [0:0] a1 = '0, b1 = '0;
  logic       busy1, done1, eq1, lt1, gt1;
  logic [0:0] bu1;
  logic [1:0] st1;

  serial_compare_ctrl #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .equal(eq1), .lesser(lt1), .greater(gt1),
    .bits_used(bu1), .dbg_state(st1)
  );

  // ---------------- scoreboard ----------------
  // Entry layout: {equal, lesser, greater, bits_used}
  logic [6:0] exp_q[$];
  logic [3:0] exp1_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] model8(input logic [7:0] av, input logic [7:0] bv);
    logic [3:0] n;
    n = 4'd8;
    for (int i = 7; i >= 0; i--) begin
      if (av[i] != bv[i]) begin
        n = 4'(8 - i);
        break;
      end
    end
    return {av == bv, av < bv, av > bv, n};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic run8(input logic [7:0] av, input logic [7:0] bv, input bit hold);
    int n;
    bit seen;
    logic [6:0] exp;
    @(negedge clk);
    a8 = av; b8 = bv; start8 = 1'b1;
    exp_q.push_back(model8(av, bv));
    @(posedge clk); #1;
    chk("accept_busy", busy8, 1);
    chk("accept_done_low", done8, 0);
    chk("accept_flags_clear", {eq8, lt8, gt8, bu8}, 0);
    chk("accept_state", st8, S_SCAN);
    @(negedge clk);
    if (hold) begin a8 = 8'($urandom); b8 = 8'($urandom); end
    else start8 = 1'b0;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 12) begin
      @(posedge clk); #1;
      n++;
      if (done8) seen = 1'b1;
      else begin
        @(negedge clk);
        if (hold) begin a8 = 8'($urandom); b8 = 8'($urandom); end
      end
    end
    chk("done_seen", seen, 1);
    if (exp_q.size() == 0) chk("queue_nonempty", 0, 1);
    else begin
      exp = exp_q.pop_front();
      chk("latency", n, exp[3:0]);
      chk("result", {eq8, lt8, gt8, bu8}, exp);
      // Next edge returns to IDLE; start may still be high but must not re-accept yet.
      @(posedge clk); #1;
      chk("done_pulse_one_cycle", done8, 0);
      chk("idle_busy_low", busy8, 0);
      chk("idle_state", st8, S_IDLE);
      chk("result_held", {eq8, lt8, gt8, bu8}, exp);
    end
    @(negedge clk);
    start8 = 1'b0;
  endtask

  task automatic run1(input logic av, input logic bv);
    logic [3:0] exp;
    @(negedge clk);
    a1 = av; b1 = bv; start1 = 1'b1;
    exp1_q.push_back({av == bv, av < bv, av > bv, 1'b1});
    @(posedge clk); #1;
    chk("w1_accept_busy", busy1, 1);
    @(negedge clk);
    start1 = 1'b0;
    @(posedge clk); #1;
    chk("w1_done", done1, 1);
    if (exp1_q.size() == 0) chk("w1_queue_nonempty", 0, 1);
    else begin
      exp = exp1_q.pop_front();
      chk("w1_result", {eq1, lt1, gt1, bu1}, exp);
    end
    @(posedge clk); #1;
    chk("w1_done_low", done1, 0);
    chk("w1_idle", st1, S_IDLE);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    bit saw_done;
    logic [7:0] ra;
    #1;
    chk("reset_outputs", {busy8, done8, eq8, lt8, gt8, bu8}, 0);
    chk("reset_state", st8, S_IDLE);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    run8(8'h5A, 8'h5A, 1'b0);
    run8(8'h80, 8'h7F, 1'b0);
    run8(8'h12, 8'h13, 1'b0);
    run8(8'h0F, 8'hF0, 1'b1);
    run8(8'h00, 8'hFF, 1'b0);
    run8(8'hFF, 8'hFE, 1'b0);

    // Reset during an equal-operand scan aborts without done.
    @(negedge clk);
    a8 = 8'hC3; b8 = 8'hC3; start8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_outputs", {busy8, done8, eq8, lt8, gt8, bu8}, 0);
    chk("abort_state", st8, S_IDLE);
    saw_done = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      if (done8) saw_done = 1'b1;
    end
    chk("abort_no_done", saw_done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run8(8'h33, 8'h31, 1'b0);

    for (int k = 0; k < 6; k++) begin
      ra = 8'($urandom_range(0, 255));
      run8(ra, ra ^ 8'(1 << $urandom_range(0, 7)), 1'b0);
    end

    run1(1'b0, 1'b0);
    run1(1'b0, 1'b1);
    run1(1'b1, 1'b0);
    run1(1'b1, 1'b1);

    chk("queue_drained", exp_q.size() + exp1_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
